flopr_pipe: RTL and testbench
=============================

// Module: flopr_pipe
// PURPOSE
//  Parametrised pipeline register chain: STAGES back-to-back N-bit registers with a
//  valid bit per stage, shared advance enable (stall), synchronous flush, and
//  occupancy counter. Successor to the plain resettable flop; used between
//  pipelined-datapath stages (IF/ID, ID/EX, ...) and as a delay line.
// PARAMETERS
//  N        64  data width in bits (>=1)
//  STAGES   3   number of register stages (>=1); latency in cycles
//  RST_VAL  0   N-bit value loaded into every data stage on reset/flush/bubble
// PORTS
//  clk          in   1                    rising-edge clock
//  reset        in   1                    asynchronous, active-low reset
//  en           in   1                    1 = chain advances this edge; 0 = hold (stall)
//  flush        in   1                    1 = clear whole chain this edge (beats en)
//  d            in   N                    input data
//  d_valid      in   1                    d carries a real entry
//  q            out  N                    data of last stage
//  q_valid      out  1                    valid bit of last stage
//  stage_valid  out  STAGES               valid bits, bit 0 = first stage
//  occupancy    out  $clog2(STAGES+1)     number of valid entries in chain
// BEHAVIOUR
//  - Reset (reset==0): immediately, no clock needed: all data = RST_VAL, all valid = 0,
//    occupancy = 0, q = RST_VAL, q_valid = 0. Held while reset low; edges ignored.
//  - Edge priority when reset==1: flush > en > hold.
//  - flush==1: all data = RST_VAL, all valid = 0, occupancy = 0; d discarded, en ignored.
//  - en==1, flush==0: stage[0] <= d_valid ? {1,d} : {0,RST_VAL};
//    stage[i] <= stage[i-1] for i=1..STAGES-1; last stage's old content leaves.
//  - en==0, flush==0: every stage holds data and valid; d/d_valid ignored.
//  - Latency: entry presented with en=1 at edge k appears on q/q_valid after edge
//    k+STAGES-1 (i.e. STAGES enabled edges counting the capture); stalled edges add delay 1:1.
//  - Invalid entries (bubbles) always carry RST_VAL so q is deterministic.
//  - occupancy: registered counter, not combinational popcount.
//    en edge: next = occ + d_valid - stage_valid[STAGES-1]; simultaneous in/out -> unchanged.
//    Range 0..STAGES; can never overflow since one entry leaves per entry entering when full.
//    Invariant: occupancy == popcount(stage_valid) every cycle; assertion in RTL.
//  - STAGES==1: behaves as enable flop: q <= d on en edge; occupancy is 1 bit.
//  - Outputs q, q_valid, stage_valid, occupancy are direct register outputs (no comb path
//    from any input).
//  - Reset asserted mid-stream: chain clears asynchronously; after release, first en edge
//    loads stage[0] normally; no stale entry reappears.
// TESTING
//  1 Reset: reset=0 for 27 time units, d=all-ones, d_valid=1, en=1 -> q=RST_VAL, q_valid=0,
//    occupancy=0 throughout, including across rising edges.
//  2 Stream: N=64, STAGES=3, en=1, d_valid=1, d=0xFFFF_FFFF_FFFF_FFFF decrementing each
//    cycle -> q equals d from 2 edges earlier (3-stage capture), q_valid=1 from 3rd edge,
//    occupancy 1,2,3,3,...
//  3 Stall: full chain of A,B,C, en=0 for 4 edges with d changing -> q=A, occupancy=3 held;
//    en=1 -> q=B, then C, then new data.
//  4 Bubbles: d_valid pattern 1,0,1 with en=1 -> stage_valid=001,010,101; bubble stage
//    data = RST_VAL; occupancy 1,1,2; q_valid follows pattern after latency.
//  5 Flush vs en: full chain, flush=1 and en=1 with d_valid=1, d=0x55 -> next cycle all
//    valid=0, occupancy=0, q=RST_VAL; 0x55 not captured.
//  6 Async reset mid-op: drop reset 3 units after an edge with full chain -> q=RST_VAL,
//    valids 0 before next edge; release, push 0x12 -> appears at q after STAGES edges;
//    repeat with STAGES=1 instance: q follows d one edge later.

Source files
------------

// File: rtl/flopr_pipe.sv
// flopr_pipe: STAGES-deep register chain with per-stage valid bits, stall, flush and occupancy count.
module flopr_pipe #(
    parameter int N = 64,
    parameter int STAGES = 3,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           flush,
    input  logic [N-1:0]                   d,
    input  logic                           d_valid,
    output logic [N-1:0]                   q,
    output logic                           q_valid,
    output logic [STAGES-1:0]              stage_valid,
    output logic [$clog2(STAGES+1)-1:0]    occupancy
);
    localparam int OW = $clog2(STAGES + 1);
    logic [N-1:0]      data [STAGES];
    logic [STAGES-1:0] vld;
    logic [OW-1:0]     occ;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            for (int i = 0; i < STAGES; i++) data[i] <= RST_VAL;
            vld <= '0;
            occ <= '0;
        end else if (en) begin
            // bubbles carry RST_VAL so q stays deterministic
            data[0] <= d_valid ? d : RST_VAL;
            vld[0]  <= d_valid;
            for (int i = 1; i < STAGES; i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
            occ <= occ + OW'(d_valid) - OW'(vld[STAGES-1]);
        end
    end
    assign q           = data[STAGES-1];
    assign q_valid     = vld[STAGES-1];
    assign stage_valid = vld;
    assign occupancy   = occ;
    occ_matches_valids: assert property (@(posedge clk) disable iff (!reset) occ == OW'($countones(vld)));
endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: directed stimulus with a queue scoreboard on the chain output plus hand-computed state checks.
module tb_flopr_pipe;
    localparam logic [63:0] RV   = 64'h0BAD_F00D_0BAD_F00D;
    localparam logic [63:0] ONES = '1;
    localparam logic [63:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] B = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] C = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] D = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] E = 64'hEEEE_EEEE_EEEE_EEEE;
    localparam logic [63:0] F = 64'h1111_2222_3333_4444;

    logic        clk = 1'b0;
    logic        reset, en, flush, d_valid;
    logic [63:0] d, q;
    logic        q_valid;
    logic [2:0]  sv;
    logic [1:0]  occ;
    logic [7:0]  q1;
    logic        qv1;
    logic [0:0]  sv1;
    logic [0:0]  occ1;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    flopr_pipe #(.N(64), .STAGES(3), .RST_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q), .q_valid(q_valid), .stage_valid(sv), .occupancy(occ)
    );

    flopr_pipe #(.N(8), .STAGES(1), .RST_VAL(8'hA5)) u1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d[7:0]), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .stage_valid(sv1), .occupancy(occ1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        check({name, "_q"}, q, RV);
        check({name, "_qv"}, 64'(q_valid), 64'd0);
        check({name, "_sv"}, 64'(sv), 64'd0);
        check({name, "_occ"}, 64'(occ), 64'd0);
    endtask

    task automatic step(input logic e, input logic f, input logic v, input logic [63:0] dd);
        en = e; flush = f; d_valid = v; d = dd;
        if (f) exp_q.delete();
        else if (e && v) exp_q.push_back(dd);
        @(posedge clk);
        #1;
    endtask

    // An entry leaves the chain on each enabled, unflushed edge while q_valid is high.
    always @(negedge clk) begin
        if (reset && !flush && en && q_valid) begin
            if (exp_q.size() == 0) check("sb_unexpected", q, ~q);
            else check("sb_q", q, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b1; flush = 1'b0; d_valid = 1'b1; d = ONES;
        #1 reset = 1'b0;
        #1 chk_idle("rst_t2");
        check("rst_u1_q", 64'(q1), 64'hA5);
        #8 chk_idle("rst_t10");
        #10 chk_idle("rst_t20");
        #6 chk_idle("rst_t26");
        #1 en = 1'b0; d_valid = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_idle("rel_hold");

        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1, ONES - 64'(k));
            check("str_occ", 64'(occ), (k < 2) ? 64'(k + 1) : 64'd3);
            check("str_qv", 64'(q_valid), (k >= 2) ? 64'd1 : 64'd0);
            check("str_q", q, (k >= 2) ? ONES - 64'(k - 2) : RV);
        end

        step(1, 0, 1, A);
        step(1, 0, 1, B);
        step(1, 0, 1, C);
        check("full_q", q, A);
        check("full_occ", 64'(occ), 64'd3);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 64'h9000 + 64'(k));
            check("stall_q", q, A);
            check("stall_occ", 64'(occ), 64'd3);
            check("stall_sv", 64'(sv), 64'b111);
            check("stall_u1", 64'(q1), 64'hCC);
        end
        step(1, 0, 1, D);
        check("resume_q1", q, B);
        step(1, 0, 1, E);
        check("resume_q2", q, C);
        step(1, 0, 1, F);
        check("resume_q3", q, D);

        step(1, 1, 1, 64'h55);
        chk_idle("flush");
        check("flush_u1", 64'(q1), 64'hA5);
        step(0, 0, 0, 64'h0);
        chk_idle("post_flush");

        step(1, 0, 1, 64'h11);
        check("bub_sv0", 64'(sv), 64'b001);
        check("bub_occ0", 64'(occ), 64'd1);
        step(1, 0, 0, 64'h22);
        check("bub_sv1", 64'(sv), 64'b010);
        check("bub_occ1", 64'(occ), 64'd1);
        step(1, 0, 1, 64'h33);
        check("bub_sv2", 64'(sv), 64'b101);
        check("bub_occ2", 64'(occ), 64'd2);
        check("bub_q2", q, 64'h11);
        step(1, 0, 0, 64'h44);
        check("bub_sv3", 64'(sv), 64'b010);
        check("bub_q3", q, RV);
        check("bub_qv3", 64'(q_valid), 64'd0);
        check("bub_occ3", 64'(occ), 64'd1);
        step(1, 0, 0, 64'h0);
        check("bub_q4", q, 64'h33);
        step(1, 0, 0, 64'h0);
        chk_idle("bub_empty");

        step(1, 0, 1, 64'h01);
        step(1, 0, 1, 64'h02);
        step(1, 0, 1, 64'h03);
        check("pre_arst_occ", 64'(occ), 64'd3);
        en = 1'b0; d_valid = 1'b0;
        #2 reset = 1'b0;
        exp_q.delete();
        #1 chk_idle("arst");
        check("arst_u1", 64'(q1), 64'hA5);
        check("arst_u1_occ", 64'(occ1), 64'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_idle("arst_rel");
        step(1, 0, 1, 64'h12);
        check("u1_q", 64'(q1), 64'h12);
        check("u1_qv", 64'(qv1), 64'd1);
        check("u1_occ", 64'(occ1), 64'd1);
        check("rl_qv0", 64'(q_valid), 64'd0);
        step(1, 0, 0, 64'h0);
        check("u1_bub", 64'(q1), 64'hA5);
        check("u1_sv", 64'(sv1), 64'd0);
        check("rl_qv1", 64'(q_valid), 64'd0);
        step(1, 0, 0, 64'h0);
        check("rl_q", q, 64'h12);
        check("rl_qv", 64'(q_valid), 64'd1);
        step(1, 0, 0, 64'h0);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
